multi_dataflow_stream_ctrl: RTL and testbench

- Parametrised job-level stream controller between the HWPE streamer and a multi-port dataflow engine.
- Generalises the single in/out stream pairing to N_IN input and N_OUT output channels.
- Per-input-channel elastic FIFOs; per-channel token counting against programmed job lengths.
- Generates busy/done/error status for the control slave.

---
 rtl/multi_dataflow_stream_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_multi_dataflow_stream_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_dataflow_stream_ctrl.sv
// Job-level stream controller for N_IN input and N_OUT output dataflow channels.
// Inputs are buffered in per-channel FIFOs; outputs pass through gated by job length.
module multi_dataflow_stream_ctrl #(
    parameter int N_IN       = 2,
    parameter int N_OUT      = 2,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [N_IN*CNT_W-1:0]  in_len_i,
    input  logic [N_OUT*CNT_W-1:0] out_len_i,
    input  logic [N_IN-1:0]        in_mask_i,
    input  logic [N_OUT-1:0]       out_mask_i,
    input  logic [N_IN-1:0]        in_valid_i,
    input  logic [N_IN*DW-1:0]     in_data_i,
    output logic [N_IN-1:0]        in_ready_o,
    output logic [N_IN-1:0]        eng_in_valid_o,
    output logic [N_IN*DW-1:0]     eng_in_data_o,
    input  logic [N_IN-1:0]        eng_in_ready_i,
    input  logic [N_OUT-1:0]       eng_out_valid_i,
    input  logic [N_OUT*DW-1:0]    eng_out_data_i,
    output logic [N_OUT-1:0]       eng_out_ready_o,
    output logic [N_OUT-1:0]       out_valid_o,
    output logic [N_OUT*DW-1:0]    out_data_o,
    input  logic [N_OUT-1:0]       out_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   err_q, err_d;

    logic [N_IN-1:0][CNT_W-1:0]  in_len_q, in_len_d;
    logic [N_IN-1:0][CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [N_OUT-1:0][CNT_W-1:0] out_len_q, out_len_d;
    logic [N_OUT-1:0][CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [N_IN-1:0]             in_mask_q, in_mask_d;
    logic [N_OUT-1:0]            out_mask_q, out_mask_d;

    logic [N_IN-1:0][AW:0]       wptr_q, wptr_d;
    logic [N_IN-1:0][AW:0]       rptr_q, rptr_d;
    logic [N_IN-1:0][FIFO_DEPTH-1:0][DW-1:0] mem_q, mem_d;

    logic             run;
    logic             all_done;
    logic [N_IN-1:0]  empty, full, push, pop, in_rdy, eng_vld;
    logic [N_OUT-1:0] gate, out_hs;

    always_comb begin
        run      = (state_q == RUN);
        all_done = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            empty[i]   = (wptr_q[i] == rptr_q[i]);
            full[i]    = (wptr_q[i][AW] != rptr_q[i][AW]) &&
                         (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
            in_rdy[i]  = run && in_mask_q[i] &&
                         (in_cnt_q[i] < in_len_q[i]) && !full[i];
            push[i]    = in_valid_i[i] && in_rdy[i];
            eng_vld[i] = run && !empty[i];
            pop[i]     = eng_vld[i] && eng_in_ready_i[i];
            if (in_mask_q[i] && ((in_cnt_q[i] != in_len_q[i]) || !empty[i]))
                all_done = 1'b0;
        end
        for (int j = 0; j < N_OUT; j++) begin
            gate[j]   = run && out_mask_q[j] && (out_cnt_q[j] < out_len_q[j]);
            out_hs[j] = eng_out_valid_i[j] && gate[j] && out_ready_i[j];
            if (out_mask_q[j] && (out_cnt_q[j] != out_len_q[j]))
                all_done = 1'b0;
        end
    end

    assign in_ready_o      = in_rdy;
    assign eng_in_valid_o  = eng_vld;
    assign out_valid_o     = eng_out_valid_i & gate;
    assign eng_out_ready_o = out_ready_i & gate;
    assign out_data_o      = eng_out_data_i;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;

    for (genvar i = 0; i < N_IN; i++) begin : g_in_data
        assign eng_in_data_o[i*DW +: DW] =
            eng_vld[i] ? mem_q[i][rptr_q[i][AW-1:0]] : '0;
    end

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        in_len_d   = in_len_q;
        in_cnt_d   = in_cnt_q;
        out_len_d  = out_len_q;
        out_cnt_d  = out_cnt_q;
        in_mask_d  = in_mask_q;
        out_mask_d = out_mask_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        mem_d      = mem_q;

        if (clear_i) begin
            state_d   = IDLE;
            err_d     = 1'b0;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            wptr_d    = '0;
            rptr_d    = '0;
        end else begin
            if (start_i && (state_q != IDLE))
                err_d = 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d    = RUN;
                        in_mask_d  = in_mask_i;
                        out_mask_d = out_mask_i;
                        in_cnt_d   = '0;
                        out_cnt_d  = '0;
                        wptr_d     = '0;
                        rptr_d     = '0;
                        for (int i = 0; i < N_IN; i++)
                            in_len_d[i] = in_len_i[i*CNT_W +: CNT_W];
                        for (int j = 0; j < N_OUT; j++)
                            out_len_d[j] = out_len_i[j*CNT_W +: CNT_W];
                    end
                end
                RUN: begin
                    for (int i = 0; i < N_IN; i++) begin
                        if (push[i]) begin
                            mem_d[i][wptr_q[i][AW-1:0]] = in_data_i[i*DW +: DW];
                            wptr_d[i]   = wptr_q[i] + PTR_ONE;
                            in_cnt_d[i] = in_cnt_q[i] + CNT_ONE;
                        end
                        if (pop[i])
                            rptr_d[i] = rptr_q[i] + PTR_ONE;
                    end
                    for (int j = 0; j < N_OUT; j++) begin
                        if (out_hs[j])
                            out_cnt_d[j] = out_cnt_q[j] + CNT_ONE;
                    end
                    if (all_done)
                        state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // status flags mirror the state being entered so they stay registered
        busy_d = (state_d == RUN) || (state_d == DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            in_len_q   <= '0;
            in_cnt_q   <= '0;
            out_len_q  <= '0;
            out_cnt_q  <= '0;
            in_mask_q  <= '0;
            out_mask_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            mem_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            in_len_q   <= in_len_d;
            in_cnt_q   <= in_cnt_d;
            out_len_q  <= out_len_d;
            out_cnt_q  <= out_cnt_d;
            in_mask_q  <= in_mask_d;
            out_mask_q <= out_mask_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_multi_dataflow_stream_ctrl.sv
// Scoreboard bench for multi_dataflow_stream_ctrl: queued expectations,
// negedge monitors for engine-input and streamer-output handshakes.
module tb_multi_dataflow_stream_ctrl;

    localparam int N_IN  = 2;
    localparam int N_OUT = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic                   clear_i;
    logic                   start_i;
    logic [N_IN*CNT_W-1:0]  in_len_i;
    logic [N_OUT*CNT_W-1:0] out_len_i;
    logic [N_IN-1:0]        in_mask_i;
    logic [N_OUT-1:0]       out_mask_i;
    logic [N_IN-1:0]        in_valid_i;
    logic [N_IN*DW-1:0]     in_data_i;
    logic [N_IN-1:0]        in_ready_o;
    logic [N_IN-1:0]        eng_in_valid_o;
    logic [N_IN*DW-1:0]     eng_in_data_o;
    logic [N_IN-1:0]        eng_in_ready_i;
    logic [N_OUT-1:0]       eng_out_valid_i;
    logic [N_OUT*DW-1:0]    eng_out_data_i;
    logic [N_OUT-1:0]       eng_out_ready_o;
    logic [N_OUT-1:0]       out_valid_o;
    logic [N_OUT*DW-1:0]    out_data_o;
    logic [N_OUT-1:0]       out_ready_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   err_o;

    multi_dataflow_stream_ctrl #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .in_len_i(in_len_i), .out_len_i(out_len_i),
        .in_mask_i(in_mask_i), .out_mask_i(out_mask_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .eng_in_valid_o(eng_in_valid_o), .eng_in_data_o(eng_in_data_o),
        .eng_in_ready_i(eng_in_ready_i),
        .eng_out_valid_i(eng_out_valid_i), .eng_out_data_i(eng_out_data_i),
        .eng_out_ready_o(eng_out_ready_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src_in  [N_IN][$];
    logic [DW-1:0] src_out [N_OUT][$];
    logic [DW-1:0] exp_in  [N_IN][$];
    logic [DW-1:0] exp_out [N_OUT][$];

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // source driver: advance each queue after an observed handshake
    initial begin
        logic [N_IN-1:0]  hs_i;
        logic [N_OUT-1:0] hs_o;
        logic [DW-1:0]    dmy;
        in_valid_i      = '0;
        in_data_i       = '0;
        eng_out_valid_i = '0;
        eng_out_data_i  = '0;
        forever begin
            @(negedge clk);
            hs_i = in_valid_i & in_ready_o;
            hs_o = eng_out_valid_i & eng_out_ready_o;
            @(posedge clk);
            #1;
            for (int i = 0; i < N_IN; i++) begin
                if (hs_i[i] && src_in[i].size() > 0) dmy = src_in[i].pop_front();
                in_valid_i[i] = src_in[i].size() > 0;
                in_data_i[i*DW +: DW] = (src_in[i].size() > 0) ? src_in[i][0] : '0;
            end
            for (int j = 0; j < N_OUT; j++) begin
                if (hs_o[j] && src_out[j].size() > 0) dmy = src_out[j].pop_front();
                eng_out_valid_i[j] = src_out[j].size() > 0;
                eng_out_data_i[j*DW +: DW] = (src_out[j].size() > 0) ? src_out[j][0] : '0;
            end
        end
    end

    // monitor: compare every delivered word with the scoreboard
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (done_o) done_cnt++;
            for (int i = 0; i < N_IN; i++) begin
                if (eng_in_valid_o[i] && eng_in_ready_i[i]) begin
                    if (exp_in[i].size() == 0) begin
                        check($sformatf("eng_in%0d_unexpected", i), 1, 0);
                    end else begin
                        e = exp_in[i].pop_front();
                        check($sformatf("eng_in%0d_data", i),
                              eng_in_data_o[i*DW +: DW], e);
                    end
                end
            end
            for (int j = 0; j < N_OUT; j++) begin
                if (out_valid_o[j] && out_ready_i[j]) begin
                    if (exp_out[j].size() == 0) begin
                        check($sformatf("out%0d_unexpected", j), 1, 0);
                    end else begin
                        e = exp_out[j].pop_front();
                        check($sformatf("out%0d_data", j),
                              out_data_o[j*DW +: DW], e);
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1;
                break;
            end
        end
        check(name, seen, 1);
    endtask

    task automatic flush_src();
        for (int i = 0; i < N_IN; i++) src_in[i].delete();
        for (int j = 0; j < N_OUT; j++) src_out[j].delete();
    endtask

    int dc;

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
        in_len_i = '0; out_len_i = '0; in_mask_i = '0; out_mask_i = '0;
        eng_in_ready_i = '0; out_ready_i = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_in_ready", in_ready_o, 0);
        check("rst_eng_in_valid", eng_in_valid_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_eng_out_ready", eng_out_ready_o, 0);
        rst_i = 1'b0;
        @(negedge clk);

        // job 1: in_len={4,3}, out_len={2,5}, one excess word on in1 and out0
        in_len_i  = {16'd3, 16'd4};
        out_len_i = {16'd5, 16'd2};
        in_mask_i = 2'b11; out_mask_i = 2'b11;
        eng_in_ready_i = 2'b11; out_ready_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            src_in[0].push_back(32'hA000_0000 + k);
            exp_in[0].push_back(32'hA000_0000 + k);
        end
        for (int k = 0; k < 4; k++) src_in[1].push_back(32'hB000_0000 + k);
        for (int k = 0; k < 3; k++) exp_in[1].push_back(32'hB000_0000 + k);
        for (int k = 0; k < 3; k++) src_out[0].push_back(32'hC000_0000 + k);
        for (int k = 0; k < 2; k++) exp_out[0].push_back(32'hC000_0000 + k);
        for (int k = 0; k < 5; k++) begin
            src_out[1].push_back(32'hD000_0000 + k);
            exp_out[1].push_back(32'hD000_0000 + k);
        end
        dc = done_cnt;
        pulse_start();
        @(negedge clk);
        check("j1_busy_run", busy_o, 1);
        check("j1_in0_ready", in_ready_o[0], 1);
        check("j1_eng0_latency", eng_in_valid_o[0], 0);
        @(negedge clk);
        check("j1_eng0_valid", eng_in_valid_o[0], 1);
        @(negedge clk);
        check("j1_out0_stall_valid", out_valid_o[0], 0);
        check("j1_out0_stall_ready", eng_out_ready_o[0], 0);
        check("j1_out0_engine_pending", eng_out_valid_i[0], 1);
        @(negedge clk);
        check("j1_in1_excess_ready", in_ready_o[1], 0);
        repeat (2) @(negedge clk);
        check("j1_no_early_done", done_o, 0);
        @(negedge clk);
        check("j1_done_cycle", done_o, 1);
        check("j1_busy_with_done", busy_o, 1);
        @(negedge clk);
        check("j1_done_one_cycle", done_o, 0);
        check("j1_busy_fall", busy_o, 0);
        check("j1_done_count", done_cnt - dc, 1);
        check("j1_exp_in0_drained", exp_in[0].size(), 0);
        check("j1_exp_in1_drained", exp_in[1].size(), 0);
        check("j1_exp_out0_drained", exp_out[0].size(), 0);
        check("j1_exp_out1_drained", exp_out[1].size(), 0);
        flush_src();
        repeat (2) @(negedge clk);

        // job 2: backpressure on in0, 6 words through a 4-deep FIFO
        in_len_i  = {16'd0, 16'd6};
        out_len_i = '0;
        in_mask_i = 2'b01; out_mask_i = 2'b00;
        eng_in_ready_i = 2'b00;
        for (int k = 0; k < 6; k++) begin
            src_in[0].push_back(32'h1111_0000 + k);
            exp_in[0].push_back(32'h1111_0000 + k);
        end
        pulse_start();
        repeat (5) @(negedge clk);
        check("j2_full_ready", in_ready_o[0], 0);
        check("j2_full_valid", eng_in_valid_o[0], 1);
        check("j2_src_left", src_in[0].size(), 2);
        repeat (2) @(negedge clk);
        check("j2_still_stalled", in_ready_o[0], 0);
        @(posedge clk); #1 eng_in_ready_i = 2'b01;
        wait_done(40, "j2_done_seen");
        @(negedge clk);
        check("j2_exp_drained", exp_in[0].size(), 0);
        flush_src();
        eng_in_ready_i = 2'b11;
        repeat (2) @(negedge clk);

        // job 3: masked input with length 0 completes immediately
        in_len_i  = '0;
        in_mask_i = 2'b01; out_mask_i = 2'b00;
        src_in[0].push_back(32'hDEAD_BEEF);
        pulse_start();
        @(negedge clk);
        check("j3_no_ready", in_ready_o[0], 0);
        check("j3_done_not_yet", done_o, 0);
        @(negedge clk);
        check("j3_done_at_t2", done_o, 1);
        flush_src();
        repeat (2) @(negedge clk);

        // job 4: start during RUN raises err, then clear aborts with 2 words buffered
        in_len_i  = {16'd0, 16'd2};
        in_mask_i = 2'b01; out_mask_i = 2'b00;
        eng_in_ready_i = 2'b00;
        src_in[0].push_back(32'h5555_0000);
        src_in[0].push_back(32'h5555_0001);
        pulse_start();
        pulse_start();
        @(negedge clk);
        check("j4_err_set", err_o, 1);
        check("j4_busy_kept", busy_o, 1);
        @(negedge clk);
        check("j4_buffered_valid", eng_in_valid_o[0], 1);
        check("j4_len_reached", in_ready_o[0], 0);
        dc = done_cnt;
        @(posedge clk); #1 clear_i = 1'b1;
        @(posedge clk); #1 clear_i = 1'b0;
        eng_in_ready_i = 2'b11;
        @(negedge clk);
        check("j4_clr_eng_valid", eng_in_valid_o[0], 0);
        check("j4_clr_err", err_o, 0);
        check("j4_clr_busy", busy_o, 0);
        check("j4_clr_done", done_o, 0);
        repeat (3) @(negedge clk);
        check("j4_clr_no_done", done_cnt - dc, 0);
        flush_src();

        // job 5: async reset mid-job
        out_len_i  = {16'd0, 16'd3};
        in_mask_i  = 2'b00; out_mask_i = 2'b01;
        out_ready_i = 2'b11;
        pulse_start();
        @(negedge clk);
        check("j5_out_ready_run", eng_out_ready_o[0], 1);
        #2 rst_i = 1'b1;
        #1;
        check("j5_async_busy", busy_o, 0);
        check("j5_async_out_ready", eng_out_ready_o[0], 0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check("j5_idle_after_rst", busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
